freq_meter: RTL
===============

FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 Parameter CNT_W, default 24, width of the edge counter and of the result.
REQ-002 Parameter BASE_GATE, default 1024, gate window length in clkC cycles when gate_sel=0; SHALL be at least 2.
REQ-003 clkC  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 sig_in  input  1  measured signal, asynchronous to clkC (e.g. one bit of the divider's prescaled bus).
REQ-006 start  input  1  single-cycle request to begin a measurement.
REQ-007 cont  input  1  continuous mode: re-arm automatically after each window.
REQ-008 gate_sel  input  2  window = BASE_GATE * 4^gate_sel cycles, sampled at window start.
REQ-009 count  output  CNT_W  rising edges counted in the last completed window.
REQ-010 valid  output  1  one-cycle pulse when count updates.
REQ-011 busy  output  1  high while a window is open.
REQ-012 overflow  output  1  last window's edge count exceeded 2^CNT_W-1.

Function
REQ-013 sig_in SHALL pass a 2-flop synchronizer, then a registered rising-edge detector; an edge pulse is high for exactly one clkC cycle per sig_in rising edge, 3 cycles after the edge.
REQ-014 FSM states: IDLE, GATE.
REQ-015 IDLE -> GATE when start=1, or when cont=1 on window completion; otherwise IDLE holds.
REQ-016 On entry to GATE: gate counter loaded with window length N; edge counter cleared; gate_sel latched.
REQ-017 GATE SHALL last exactly N cycles; busy=1 in all N cycles.
REQ-018 Edge pulses present in any of the N GATE cycles, including the first and the last, SHALL be counted.
REQ-019 Edge counter SHALL saturate at 2^CNT_W-1; any further edge sets the internal overflow flag.
REQ-020 In the cycle after the last GATE cycle: count and overflow update, and valid=1 for one cycle.
REQ-021 Single mode (cont=0): FSM returns to IDLE; busy=0 in the valid cycle.
REQ-022 Continuous mode (cont=1): the next window starts in the valid cycle; busy stays 1; valid repeats every N cycles.
REQ-023 start while busy=1 SHALL be ignored; start is not queued.
REQ-024 Dropping cont during a window SHALL let that window finish, then go to IDLE.
REQ-025 count and overflow SHALL hold their values between valid pulses.
REQ-026 gate_sel changes during a window SHALL take effect only at the next window start.

Reset
REQ-027 reset=1 SHALL force IDLE and clear the synchronizer, edge detector, gate counter, edge counter, count, valid, busy and overflow on the next clkC edge.
REQ-028 Reset during GATE SHALL abandon the window with no valid pulse; the count from before the reset is lost (count reads 0).
REQ-029 reset SHALL take priority over start and cont in the same cycle.

Structure
REQ-030 Package freq_meter_pkg SHALL hold the state encoding, the BASE_GATE default and the gate-length shift table.
REQ-031 Sub-module sync_edge_det (2-flop synchronizer plus rising-edge pulse) SHALL be instantiated once.
REQ-032 Gate counter width SHALL be clog2(BASE_GATE*64)+1 bits.

Verification
REQ-033 sig_in = clkC/8 square wave, gate_sel=0, start pulse -> single valid pulse, count=128 (+/-1), overflow=0, busy=0 after.
REQ-034 CNT_W=8, sig_in = clkC/2, gate_sel=0 -> count=255, overflow=1.
REQ-035 cont=1, gate_sel=1, sig_in = clkC/16 -> valid every 4096 cycles, count=256 (+/-1) each time, busy never drops.
REQ-036 start re-pulsed mid-window -> no extra window; valid exactly N+1 cycles after the first start.
REQ-037 reset asserted at GATE cycle 500 -> no valid, all outputs 0 next cycle, then a fresh start measures correctly.
REQ-038 gate_sel changed 0->2 mid-window -> current window 1024 cycles; next window (cont=1) 16384 cycles.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency meter: FSM state encoding, the default
// base gate length and the gate_sel -> window-length shift table.
package freq_meter_pkg;

    localparam int unsigned BASE_GATE_DEF = 1024;

    // FSM state encoding
    localparam int unsigned STATE_W = 1;
    localparam logic [0:0]  ST_IDLE = 1'b0;
    localparam logic [0:0]  ST_GATE = 1'b1;

    // Window = BASE_GATE * 4^gate_sel, i.e. a left shift by 2*gate_sel.
    localparam logic [3:0][2:0] GATE_SHIFT_TBL = {3'd6, 3'd4, 3'd2, 3'd0};

    function automatic logic [2:0] gate_shift(input logic [1:0] sel);
        return GATE_SHIFT_TBL[sel];
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// Ports:
//   clk_i   - sampling clock
//   rst_i   - synchronous active-high reset
//   sig_i   - asynchronous input signal
//   pulse_o - one-cycle pulse, 3 cycles after each rising edge of sig_i
module sync_edge_det (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sig_i,
    output logic pulse_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic pulse_q;

    // Synchronizer, history flop and edge pulse register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= sig_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            pulse_q <= sync2_q & ~prev_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/freq_meter.sv
// Gated frequency meter: counts rising edges of sig_in over a window of
// BASE_GATE * 4^gate_sel clkC cycles, in single-shot or continuous mode.
// Ports:
//   clkC     - clock
//   reset    - synchronous active-high reset
//   sig_in   - measured signal (asynchronous)
//   start    - single-cycle measurement request (ignored while busy)
//   cont     - continuous mode, re-arm after each window
//   gate_sel - window length select, sampled at window start
//   count    - edges counted in the last completed window (saturating)
//   valid    - one-cycle pulse when count/overflow update
//   busy     - high while a window is open
//   overflow - last window's edge count exceeded the counter range
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned CNT_W     = 24,
    parameter int unsigned BASE_GATE = BASE_GATE_DEF
) (
    input  logic             clkC,
    input  logic             reset,
    input  logic             sig_in,
    input  logic             start,
    input  logic             cont,
    input  logic [1:0]       gate_sel,
    output logic [CNT_W-1:0] count,
    output logic             valid,
    output logic             busy,
    output logic             overflow
);

    localparam int unsigned     GATE_W  = $clog2(BASE_GATE * 64) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [STATE_W-1:0] state_q,    state_d;
    logic [GATE_W-1:0]  gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0]   edge_cnt_q, edge_cnt_d;
    logic               edge_ovf_q, edge_ovf_d;
    logic [CNT_W-1:0]   count_q,    count_d;
    logic               overflow_q, overflow_d;
    logic               valid_q,    valid_d;
    logic               busy_q,     busy_d;

    logic               edge_pulse;
    logic [GATE_W-1:0]  win_len_c;
    logic [CNT_W-1:0]   cnt_inc_c;
    logic               ovf_inc_c;
    logic               last_c;

    sync_edge_det u_sync_edge_det (
        .clk_i   (clkC),
        .rst_i   (reset),
        .sig_i   (sig_in),
        .pulse_o (edge_pulse)
    );

    // Window length for the currently presented gate_sel
    assign win_len_c = GATE_W'(BASE_GATE) << gate_shift(gate_sel);

    // Current GATE cycle is the last one of the window
    assign last_c = (gate_cnt_q == GATE_W'(1));

    // Saturating edge count including this cycle's pulse
    always_comb begin
        cnt_inc_c = edge_cnt_q;
        ovf_inc_c = edge_ovf_q;
        if (edge_pulse) begin
            if (edge_cnt_q == CNT_MAX) begin
                ovf_inc_c = 1'b1;
            end else begin
                cnt_inc_c = edge_cnt_q + CNT_W'(1);
            end
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d    = state_q;
        gate_cnt_d = gate_cnt_q;
        edge_cnt_d = edge_cnt_q;
        edge_ovf_d = edge_ovf_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        valid_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_GATE;
                    gate_cnt_d = win_len_c;
                    edge_cnt_d = '0;
                    edge_ovf_d = 1'b0;
                end
            end
            ST_GATE: begin
                gate_cnt_d = gate_cnt_q - GATE_W'(1);
                edge_cnt_d = cnt_inc_c;
                edge_ovf_d = ovf_inc_c;
                if (last_c) begin
                    count_d    = cnt_inc_c;
                    overflow_d = ovf_inc_c;
                    valid_d    = 1'b1;
                    if (cont) begin
                        // Back-to-back window starts in the valid cycle
                        gate_cnt_d = win_len_c;
                        edge_cnt_d = '0;
                        edge_ovf_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_GATE);
    end

    // State and output registers
    always_ff @(posedge clkC) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            edge_ovf_q <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gate_cnt_q <= gate_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            edge_ovf_q <= edge_ovf_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
        end
    end

    assign count    = count_q;
    assign overflow = overflow_q;
    assign valid    = valid_q;
    assign busy     = busy_q;

endmodule
